// File: rtl/bsg_rom_stream_player_pkg.sv
// ============================================================================
// Module      : bsg_rom_stream_player_pkg
// Description : Shared types and constants for the ROM stream player.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bsg_rom_stream_player_pkg;

   // Player sequencing states
   typedef enum logic [1:0] {
      e_idle  = 2'd0,
      e_run   = 2'd1,
      e_drain = 2'd2,
      e_done  = 2'd3
   } state_e;

   // Depth of the output buffer; the read credit scheme is sized to it
   localparam int unsigned fifo_els_lp = 2;

   // Address width that stays at least one bit wide for single-entry ROMs
   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_fifo_1r1w_small.sv
// ============================================================================
// Module      : bsg_fifo_1r1w_small
// Description : Small register-based FIFO, one write and one read port.
//               v_o flags a valid head; yumi_i pops it. The writer must not
//               push when ready_o is low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_fifo_1r1w_small #(
   parameter int unsigned width_p = 8,
   parameter int unsigned els_p   = 2
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int unsigned ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int unsigned count_width_lp = $clog2(els_p + 1);
   localparam logic [ptr_width_lp-1:0]   last_ptr_lp = ptr_width_lp'(els_p - 1);
   localparam logic [count_width_lp-1:0] full_lp     = count_width_lp'(els_p);

   logic [width_p-1:0]        mem [els_p];
   logic [ptr_width_lp-1:0]   wr_ptr;
   logic [ptr_width_lp-1:0]   rd_ptr;
   logic [count_width_lp-1:0] count;

   // Storage array; contents are only observed when count says they are valid
   always_ff @(posedge clk_i) begin
      if (v_i) begin
         mem[wr_ptr] <= data_i;
      end
   end

   // Circular read/write pointers and occupancy count
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (v_i) begin
            wr_ptr <= (wr_ptr == last_ptr_lp) ? '0 : wr_ptr + ptr_width_lp'(1);
         end
         if (yumi_i) begin
            rd_ptr <= (rd_ptr == last_ptr_lp) ? '0 : rd_ptr + ptr_width_lp'(1);
         end
         case ({v_i, yumi_i})
            2'b10:   count <= count + count_width_lp'(1);
            2'b01:   count <= count - count_width_lp'(1);
            default: count <= count;
         endcase
      end
   end

   assign ready_o = (count != full_lp);
   assign v_o     = (count != '0);
   assign data_o  = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/bsg_rom_stream_player.sv
// ============================================================================
// Module      : bsg_rom_stream_player
// Description : Walks a 1-cycle-latency ROM from address 0 to els_p-1 and
//               streams each word out on a valid/ready interface, optionally
//               looping until stop_i. Reads are issued against a credit of
//               two buffered/in-flight words so the output never overflows.
//               Optional build macro BSG_ROM_STREAM_PLAYER_CHECKSUM_EN adds
//               checksum_o, the XOR of the words transferred in this pass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_rom_stream_player
   import bsg_rom_stream_player_pkg::*;
#(
   parameter int unsigned els_p          = 4,
   parameter int unsigned width_p        = 32,
   parameter int unsigned addr_width_lp  = safe_clog2(els_p),
   parameter int unsigned count_width_lp = $clog2(els_p + 1)
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      go_i,
   input  logic                      loop_i,
   input  logic                      stop_i,
   output logic                      rom_v_o,
   output logic [addr_width_lp-1:0]  rom_addr_o,
   input  logic [width_p-1:0]        rom_data_i,
   output logic                      v_o,
   output logic [width_p-1:0]        data_o,
   input  logic                      ready_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [count_width_lp-1:0] words_sent_o
`ifdef BSG_ROM_STREAM_PLAYER_CHECKSUM_EN
   ,
   output logic [width_p-1:0]        checksum_o
`endif
);

   localparam logic [addr_width_lp-1:0]  last_addr_lp  = addr_width_lp'(els_p - 1);
   localparam logic [count_width_lp-1:0] els_count_lp  = count_width_lp'(els_p);
   localparam logic [count_width_lp-1:0] last_count_lp = count_width_lp'(els_p - 1);
   localparam logic [2:0]                credit_lp     = 3'(fifo_els_lp);

   state_e state;
   state_e state_next;

   logic [addr_width_lp-1:0]  addr;
   logic                      looping;
   logic                      in_flight;
   logic [count_width_lp-1:0] words_sent;

   logic                      fifo_push;
   logic                      fifo_pop;
   logic                      fifo_ready;
   logic                      fifo_v;
   logic [width_p-1:0]        fifo_data;
   logic [1:0]                fifo_occ;

   logic [2:0]                pending;
   logic [2:0]                remain;
   logic                      xfer;
   logic                      start;
   logic                      credit_ok;
   logic                      last_issue;
   logic                      final_word;
   logic                      pass_end;
   logic                      pass_wrap;

   // Output buffer; the word returning from the ROM goes straight out when
   // the buffer is empty and downstream accepts, otherwise it is buffered
   bsg_fifo_1r1w_small #(
      .width_p (width_p),
      .els_p   (fifo_els_lp)
   ) fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (fifo_push),
      .data_i    (rom_data_i),
      .ready_o   (fifo_ready),
      .v_o       (fifo_v),
      .data_o    (fifo_data),
      .yumi_i    (fifo_pop)
   );

   // Buffer occupancy recovered from the two-entry FIFO's flags
   always_comb begin
      fifo_occ = 2'd0;
      if (!fifo_ready) begin
         fifo_occ = 2'(fifo_els_lp);
      end else if (fifo_v) begin
         fifo_occ = 2'd1;
      end
   end

   // Head of the stream is the oldest buffered word, else the returning word
   assign v_o       = fifo_v | in_flight;
   assign data_o    = fifo_v ? fifo_data : (in_flight ? rom_data_i : '0);
   assign xfer      = v_o & ready_i;
   assign fifo_pop  = fifo_v & ready_i;
   assign fifo_push = in_flight & (fifo_v | ~ready_i);

   // Words owed downstream now, and what is left after this cycle's transfer
   assign pending   = 3'(fifo_occ) + 3'(in_flight);
   assign remain    = pending - 3'(xfer);
   assign credit_ok = (remain < credit_lp);

   assign start      = go_i & ((state == e_idle) | (state == e_done));
   assign last_issue = rom_v_o & (addr == last_addr_lp);

   // The very last word of the final pass is the only one left while draining
   assign final_word = (state == e_drain) & (pending == 3'd1);
   assign pass_end   = xfer & (words_sent == last_count_lp);
   assign pass_wrap  = pass_end & looping & ~final_word;

   // State register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state <= e_idle;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection
   always_comb begin
      state_next = state;
      case (state)
         e_idle, e_done: begin
            if (go_i) begin
               state_next = e_run;
            end
         end
         e_run: begin
            if (last_issue && !(looping && !stop_i)) begin
               state_next = e_drain;
            end
         end
         e_drain: begin
            if (remain == 3'd0) begin
               state_next = e_done;
            end
         end
         default: state_next = e_idle;
      endcase
   end

   // State-decoded outputs; reads go out only while credit remains
   always_comb begin
      rom_v_o = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state)
         e_run: begin
            rom_v_o = credit_ok;
            busy_o  = 1'b1;
         end
         e_drain: busy_o = 1'b1;
         e_done:  done_o = 1'b1;
         default: ;
      endcase
   end

   // Read address walks 0..els_p-1 and returns to 0 after the last entry
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         addr    <= '0;
         looping <= 1'b0;
      end else if (start) begin
         addr    <= '0;
         looping <= loop_i;
      end else if (rom_v_o) begin
         addr <= (addr == last_addr_lp) ? '0 : addr + addr_width_lp'(1);
      end
   end

   // A read issued this cycle returns data next cycle
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         in_flight <= 1'b0;
      end else begin
         in_flight <= rom_v_o;
      end
   end

   // Per-pass transfer count; restarts when a looping pass completes
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         words_sent <= '0;
      end else if (start) begin
         words_sent <= '0;
      end else if (pass_wrap) begin
         words_sent <= '0;
      end else if (pass_end) begin
         words_sent <= els_count_lp;
      end else if (xfer && (words_sent != els_count_lp)) begin
         words_sent <= words_sent + count_width_lp'(1);
      end
   end

   assign rom_addr_o   = addr;
   assign words_sent_o = words_sent;

`ifdef BSG_ROM_STREAM_PLAYER_CHECKSUM_EN
   logic [width_p-1:0] checksum;

   // Running XOR of the words accepted downstream in the current pass
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         checksum <= '0;
      end else if (start) begin
         checksum <= '0;
      end else if (pass_wrap) begin
         checksum <= '0;
      end else if (xfer) begin
         checksum <= checksum ^ data_o;
      end
   end

   assign checksum_o = checksum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_rom_stream_player.sv
// ============================================================================
// Module      : tb_bsg_rom_stream_player
// Description : Self-checking bench for bsg_rom_stream_player. Instance a is
//               a 4 x 32 player, instance b a 1 x 8 player. Each ROM model
//               registers its word one cycle after the read strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_rom_stream_player;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        go_a, loop_a, stop_a, ready_a;
   logic        rom_v_a, v_a, busy_a, done_a;
   logic [1:0]  rom_addr_a;
   logic [31:0] rom_data_a, data_a;
   logic [2:0]  ws_a;
   logic [31:0] rom_a [4];

   logic        go_b, loop_b, stop_b, ready_b;
   logic        rom_v_b, v_b, busy_b, done_b;
   logic [0:0]  rom_addr_b;
   logic [7:0]  rom_data_b, data_b;
   logic [0:0]  ws_b;
   logic [7:0]  rom_b_word;

`ifdef BSG_ROM_STREAM_PLAYER_CHECKSUM_EN
   logic [31:0] cks_a;
   logic [7:0]  cks_b;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bsg_rom_stream_player #(.els_p(4), .width_p(32)) dut_a (
      .clk_i(clk), .reset_n_i(rst_n), .go_i(go_a), .loop_i(loop_a), .stop_i(stop_a),
      .rom_v_o(rom_v_a), .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a),
      .v_o(v_a), .data_o(data_a), .ready_i(ready_a),
      .busy_o(busy_a), .done_o(done_a), .words_sent_o(ws_a)
`ifdef BSG_ROM_STREAM_PLAYER_CHECKSUM_EN
      , .checksum_o(cks_a)
`endif
   );

   bsg_rom_stream_player #(.els_p(1), .width_p(8)) dut_b (
      .clk_i(clk), .reset_n_i(rst_n), .go_i(go_b), .loop_i(loop_b), .stop_i(stop_b),
      .rom_v_o(rom_v_b), .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b),
      .v_o(v_b), .data_o(data_b), .ready_i(ready_b),
      .busy_o(busy_b), .done_o(done_b), .words_sent_o(ws_b)
`ifdef BSG_ROM_STREAM_PLAYER_CHECKSUM_EN
      , .checksum_o(cks_b)
`endif
   );

   // ROM models with one cycle of read latency
   always @(posedge clk) if (rom_v_a) rom_data_a <= rom_a[rom_addr_a];
   always @(posedge clk) if (rom_v_b) rom_data_b <= rom_b_word;

   task automatic test_reset;
      rst_n = 1'b0;
      go_a = 0; loop_a = 0; stop_a = 0; ready_a = 0;
      go_b = 0; loop_b = 0; stop_b = 0; ready_b = 0;
      repeat (2) @(negedge clk);
      #1;
      total++; if (rom_v_a !== 1'b0) begin bad++; $display("FAIL reset_rom_v: got %b want 0", rom_v_a); end
      total++; if (rom_addr_a !== 2'd0) begin bad++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr_a); end
      total++; if (v_a !== 1'b0) begin bad++; $display("FAIL reset_v: got %b want 0", v_a); end
      total++; if (data_a !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", data_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
      total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_a); end
      total++; if (ws_a !== 3'd0) begin bad++; $display("FAIL reset_words_sent: got %0d want 0", ws_a); end
      total++; if ({v_b, data_b, done_b} !== 10'd0) begin bad++; $display("FAIL reset_b_outputs: got %h want 0", {v_b, data_b, done_b}); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ROM {0,1,2,3}, ready held high: fixed cycle timing from the go edge
   task automatic test_single_pass;
      for (int i = 0; i < 4; i++) rom_a[i] = i;
      ready_a = 1'b1;
      loop_a  = 1'b0;
      @(negedge clk);
      go_a = 1'b1;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         @(negedge clk);
         go_a = 1'b0;
         #1;
         total++;
         if (rom_v_a !== (cyc <= 4)) begin bad++; $display("FAIL single_rom_v c%0d: got %b want %b", cyc, rom_v_a, (cyc <= 4)); end
         if (cyc <= 4) begin
            total++;
            if (rom_addr_a !== 2'(cyc - 1)) begin bad++; $display("FAIL single_rom_addr c%0d: got %0d want %0d", cyc, rom_addr_a, cyc - 1); end
         end
         total++;
         if (v_a !== (cyc >= 2 && cyc <= 5)) begin bad++; $display("FAIL single_v c%0d: got %b want %b", cyc, v_a, (cyc >= 2 && cyc <= 5)); end
         if (cyc >= 2 && cyc <= 5) begin
            total++;
            if (data_a !== 32'(cyc - 2)) begin bad++; $display("FAIL single_data c%0d: got %0d want %0d", cyc, data_a, cyc - 2); end
         end
         total++;
         if (done_a !== (cyc >= 6)) begin bad++; $display("FAIL single_done c%0d: got %b want %b", cyc, done_a, (cyc >= 6)); end
         if (cyc == 6) begin
            total++;
            if (ws_a !== 3'd4) begin bad++; $display("FAIL single_words_sent: got %0d want 4", ws_a); end
         end
      end
   endtask

   // One pass under back-pressure: mode 0 toggles ready 1,0,1,0; mode 1 random
   task automatic test_stream(input int mode);
      int issued = 0;
      int got    = 0;
      logic [31:0] xsum = '0;
      if (mode == 0) for (int i = 0; i < 4; i++) rom_a[i] = i;
      else           for (int i = 0; i < 4; i++) rom_a[i] = $urandom;
      loop_a = 1'b0;
      @(negedge clk);
      go_a = 1'b1;
      for (int cyc = 1; cyc < 200; cyc++) begin
         @(negedge clk);
         go_a    = 1'b0;
         ready_a = (mode == 0) ? cyc[0] : 1'($urandom_range(0, 1));
         #1;
         if (done_a) break;
         total++;
         if (ws_a !== 3'(got)) begin bad++; $display("FAIL stream_words_sent: got %0d want %0d", ws_a, got); end
         if (v_a && ready_a) begin
            total++;
            if (got >= 4 || data_a !== rom_a[got % 4]) begin
               bad++; $display("FAIL stream_data #%0d: got %h want %h", got, data_a, rom_a[got % 4]);
            end
            xsum ^= data_a;
            got++;
         end
         if (rom_v_a) begin
            total++;
            if (rom_addr_a !== 2'(issued % 4)) begin bad++; $display("FAIL stream_addr: got %0d want %0d", rom_addr_a, issued % 4); end
            issued++;
         end
         total++;
         if (issued - got > 2) begin bad++; $display("FAIL stream_outstanding: got %0d want <=2", issued - got); end
      end
      total++; if (done_a !== 1'b1) begin bad++; $display("FAIL stream_timeout: done got %b want 1", done_a); end
      total++; if (got != 4) begin bad++; $display("FAIL stream_count: got %0d want 4", got); end
      total++; if (ws_a !== 3'd4) begin bad++; $display("FAIL stream_final_words_sent: got %0d want 4", ws_a); end
`ifdef BSG_ROM_STREAM_PLAYER_CHECKSUM_EN
      total++; if (cks_a !== xsum) begin bad++; $display("FAIL stream_checksum: got %h want %h", cks_a, xsum); end
`endif
      ready_a = 1'b1;
   endtask

   // Looping playback, stop raised during the second pass
   task automatic test_loop_stop;
      int got = 0;
      for (int i = 0; i < 4; i++) rom_a[i] = $urandom;
      loop_a  = 1'b1;
      stop_a  = 1'b0;
      ready_a = 1'b1;
      @(negedge clk);
      go_a = 1'b1;
      for (int cyc = 1; cyc < 100; cyc++) begin
         @(negedge clk);
         go_a = 1'b0;
         #1;
         if (done_a) break;
         total++;
         if (ws_a !== 3'(got % 4)) begin bad++; $display("FAIL loop_words_sent after %0d: got %0d want %0d", got, ws_a, got % 4); end
         if (v_a && ready_a) begin
            total++;
            if (got >= 8 || data_a !== rom_a[got % 4]) begin
               bad++; $display("FAIL loop_data #%0d: got %h want %h", got, data_a, rom_a[got % 4]);
            end
            got++;
            if (got == 5) stop_a = 1'b1;
         end
      end
      total++; if (done_a !== 1'b1) begin bad++; $display("FAIL loop_timeout: done got %b want 1", done_a); end
      total++; if (got != 8) begin bad++; $display("FAIL loop_count: got %0d want 8", got); end
      total++; if (ws_a !== 3'd4) begin bad++; $display("FAIL loop_final_words_sent: got %0d want 4", ws_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL loop_busy: got %b want 0", busy_a); end
      stop_a = 1'b0;
      loop_a = 1'b0;
   endtask

   // Reset while two words sit in the output buffer
   task automatic test_reset_mid_pass;
      int got  = 0;
      int held = 0;
      for (int i = 0; i < 4; i++) rom_a[i] = $urandom;
      loop_a = 1'b0;
      @(negedge clk);
      go_a = 1'b1;
      for (int cyc = 1; cyc < 40; cyc++) begin
         @(negedge clk);
         go_a    = 1'b0;
         ready_a = (got < 2);
         #1;
         if (v_a && ready_a) got++;
         if (!ready_a) held++;
         if (held == 4) break;
      end
      total++; if (v_a !== 1'b1 || busy_a !== 1'b1) begin bad++; $display("FAIL midreset_pre: v/busy got %b%b want 11", v_a, busy_a); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({rom_v_a, rom_addr_a, v_a, data_a, busy_a, done_a, ws_a} !== 41'd0) begin
         bad++; $display("FAIL midreset_outputs: got %h want 0", {rom_v_a, rom_addr_a, v_a, data_a, busy_a, done_a, ws_a});
      end
      @(negedge clk);
      rst_n   = 1'b1;
      ready_a = 1'b1;
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         #1;
         total++;
         if (v_a !== 1'b0 || rom_v_a !== 1'b0) begin bad++; $display("FAIL midreset_quiet: v/rom_v got %b%b want 00", v_a, rom_v_a); end
      end
      got = 0;
      @(negedge clk);
      go_a = 1'b1;
      for (int cyc = 1; cyc < 50; cyc++) begin
         @(negedge clk);
         go_a = 1'b0;
         #1;
         if (done_a) break;
         if (v_a && ready_a) begin
            total++;
            if (got >= 4 || data_a !== rom_a[got % 4]) begin bad++; $display("FAIL midreset_data #%0d: got %h want %h", got, data_a, rom_a[got % 4]); end
            got++;
         end
      end
      total++; if (done_a !== 1'b1 || got != 4) begin bad++; $display("FAIL midreset_rerun: done %b count %0d want 1 and 4", done_a, got); end
   endtask

   // Single-entry ROM looping: a word every cycle, go ignored while busy
   task automatic test_els1;
      rom_b_word = 8'hA5;
      loop_b  = 1'b1;
      stop_b  = 1'b0;
      ready_b = 1'b1;
      @(negedge clk);
      go_b = 1'b1;
      for (int cyc = 1; cyc < 20; cyc++) begin
         @(negedge clk);
         go_b = (cyc == 10);
         #1;
         total++;
         if (rom_addr_b !== 1'b0) begin bad++; $display("FAIL els1_addr c%0d: got %0d want 0", cyc, rom_addr_b); end
         if (cyc >= 2) begin
            total++;
            if (v_b !== 1'b1 || data_b !== 8'hA5) begin bad++; $display("FAIL els1_stream c%0d: v %b data %h want 1 a5", cyc, v_b, data_b); end
            total++;
            if (busy_b !== 1'b1) begin bad++; $display("FAIL els1_busy c%0d: got %b want 1", cyc, busy_b); end
         end
         if (cyc >= 3) begin
            total++;
            if (ws_b !== 1'b0) begin bad++; $display("FAIL els1_words_sent c%0d: got %0d want 0", cyc, ws_b); end
         end
      end
      @(negedge clk);
      go_b   = 1'b0;
      stop_b = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         #1;
         if (done_b) break;
      end
      total++; if (done_b !== 1'b1) begin bad++; $display("FAIL els1_done: got %b want 1", done_b); end
      total++; if (ws_b !== 1'b1) begin bad++; $display("FAIL els1_final_words_sent: got %0d want 1", ws_b); end
      stop_b = 1'b0;
      loop_b = 1'b0;
   endtask

`ifdef BSG_ROM_STREAM_PLAYER_CHECKSUM_EN
   // ROM {1,2,4,8}: checksum in DONE is their XOR
   task automatic test_checksum;
      rom_a[0] = 32'd1; rom_a[1] = 32'd2; rom_a[2] = 32'd4; rom_a[3] = 32'd8;
      loop_a  = 1'b0;
      ready_a = 1'b1;
      @(negedge clk);
      go_a = 1'b1;
      for (int cyc = 1; cyc < 30; cyc++) begin
         @(negedge clk);
         go_a = 1'b0;
         #1;
         if (done_a) break;
      end
      total++; if (done_a !== 1'b1) begin bad++; $display("FAIL checksum_timeout: done got %b want 1", done_a); end
      total++; if (cks_a !== 32'hF) begin bad++; $display("FAIL checksum_value: got %h want f", cks_a); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_pass();
      test_stream(0);
      test_stream(1);
      test_stream(1);
      test_loop_stop();
      test_reset_mid_pass();
      test_els1();
`ifdef BSG_ROM_STREAM_PLAYER_CHECKSUM_EN
      test_checksum();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
